// File: rtl/execute_sequencer_pkg.sv
// Shared control definitions for the execute sequencer: FSM states, one-hot op/encoding
// decode types, writeback/PC select codes and op classification helpers.
package execute_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } exec_state_e;

    // Bit positions within the one-hot InstructionSet decode (RV32I base).
    typedef enum int unsigned {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_COUNT
    } op_idx_e;

    // Bit positions within the one-hot EncodingType decode.
    typedef enum int unsigned {
        ENC_R, ENC_I, ENC_S, ENC_B, ENC_U, ENC_J,
        ENC_COUNT
    } enc_idx_e;

    localparam int unsigned OP_W  = OP_COUNT;
    localparam int unsigned ENC_W = ENC_COUNT;

    typedef logic [OP_W-1:0]  instruction_set_t;
    typedef logic [ENC_W-1:0] encoding_type_t;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    localparam logic PC_SEL_PC4 = 1'b0;
    localparam logic PC_SEL_ALU = 1'b1;

    function automatic logic is_load(instruction_set_t op);
        return op[OP_LB] | op[OP_LH] | op[OP_LW] | op[OP_LBU] | op[OP_LHU];
    endfunction

    function automatic logic is_store(instruction_set_t op);
        return op[OP_SB] | op[OP_SH] | op[OP_SW];
    endfunction

    function automatic logic is_jump(instruction_set_t op);
        return op[OP_JAL] | op[OP_JALR];
    endfunction

    function automatic logic is_branch(instruction_set_t op);
        return op[OP_BEQ] | op[OP_BNE] | op[OP_BLT] | op[OP_BGE] | op[OP_BLTU] | op[OP_BGEU];
    endfunction

    // BEQ/BLT/BLTU take on a true compare, BNE/BGE/BGEU on a false one, jumps always.
    function automatic logic resolve_branch(instruction_set_t op, logic out_b);
        logic direct;
        logic inverted;
        direct   = op[OP_BEQ] | op[OP_BLT] | op[OP_BLTU];
        inverted = op[OP_BNE] | op[OP_BGE] | op[OP_BGEU];
        return (direct & out_b) | (inverted & ~out_b) | is_jump(op);
    endfunction

    function automatic logic [1:0] wb_select(instruction_set_t op);
        if (is_load(op)) begin
            return WB_SEL_LOAD;
        end
        if (is_jump(op)) begin
            return WB_SEL_PC4;
        end
        return WB_SEL_ALU;
    endfunction

endpackage

// File: rtl/execute_sequencer_perf_counters.sv
// Free-running wrap-around cycle and retired-instruction counters for the execute sequencer.
module execute_sequencer_perf_counters #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_cycle,
    input  logic             inc_ret,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            if (inc_cycle) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (inc_ret) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/execute_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM for the single-issue core.
// Define EXEC_SEQ_PERF_COUNTERS_EN to build the cycle/instret performance counters.
module execute_sequencer
    import execute_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W          = 64,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    input  instruction_set_t op,
    input  encoding_type_t   en,
    input  logic             alu_out_b,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_load,
    output logic             pc_sel,
    output logic             busy,
    output logic             trap,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    exec_state_e     state;
    exec_state_e     state_nxt;
    logic [TO_W-1:0] wait_cnt;
    logic            timeout_c;
    logic            branch_taken;
    logic            branch_take_c;
    logic            wait_hold_c;

    // Last permitted wait cycle of a pending request; disabled when TIMEOUT_CYCLES is 0.
    assign timeout_c     = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign branch_take_c = resolve_branch(op, alu_out_b);
    assign wait_hold_c   = (state_nxt == state) && ((state == ST_FETCH) || (state == ST_MEM));

    // Only combinational output: IR captures fetch data in the ack cycle.
    assign ir_load = (state == ST_FETCH) && imem_ack;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_nxt = ST_DECODE;
                end else if (timeout_c) begin
                    state_nxt = ST_TRAP;
                end
            end
            ST_DECODE: begin
                state_nxt = ((op == '0) || (en == '0)) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = (is_load(op) || is_store(op)) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_nxt = ST_WB;
                end else if (timeout_c) begin
                    state_nxt = ST_TRAP;
                end
            end
            ST_WB: begin
                state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                state_nxt = ST_TRAP;
            end
            default: begin
                state_nxt = ST_TRAP;
            end
        endcase
    end

    // State register plus Moore outputs registered from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            branch_taken <= 1'b0;
            imem_req     <= 1'b0;
            alu_en       <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            rf_we        <= 1'b0;
            wb_sel       <= WB_SEL_ALU;
            pc_load      <= 1'b0;
            pc_sel       <= PC_SEL_PC4;
            busy         <= 1'b0;
            trap         <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_hold_c ? (wait_cnt + TO_W'(1)) : '0;

            if (state == ST_EXEC) begin
                branch_taken <= branch_take_c;
            end

            imem_req <= (state_nxt == ST_FETCH);
            alu_en   <= (state_nxt == ST_EXEC);
            dmem_req <= (state_nxt == ST_MEM);
            dmem_we  <= (state_nxt == ST_MEM) && is_store(op);
            pc_load  <= (state_nxt == ST_WB);
            rf_we    <= (state_nxt == ST_WB) && !is_branch(op) && !is_store(op);
            wb_sel   <= (state_nxt == ST_WB) ? wb_select(op) : WB_SEL_ALU;
            busy     <= (state_nxt != ST_IDLE) && (state_nxt != ST_TRAP);
            trap     <= (state_nxt == ST_TRAP);

            // Leaving EXEC the branch flop is still being written, so bypass its input.
            if (state_nxt == ST_WB) begin
                pc_sel <= ((state == ST_EXEC) ? branch_take_c : branch_taken) ? PC_SEL_ALU
                                                                               : PC_SEL_PC4;
            end else begin
                pc_sel <= PC_SEL_PC4;
            end
        end
    end

`ifdef EXEC_SEQ_PERF_COUNTERS_EN
    logic retire_c;

    assign retire_c = (state == ST_WB);

    execute_sequencer_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf_counters (
        .clk        (clk),
        .reset      (reset),
        .inc_cycle  (busy),
        .inc_ret    (retire_c),
        .cycle_count(cycle_count),
        .instret    (instret)
    );
`else
    assign cycle_count = '0;
    assign instret     = '0;
`endif

endmodule

// File: tb/tb_execute_sequencer.sv
// Randomized bench for execute_sequencer: a per-instruction cycle schedule built from the
// instruction class rules drives inputs and supplies the expected outputs for every cycle.
module tb_execute_sequencer;
    import execute_sequencer_pkg::*;

    localparam int unsigned CNT_W = 64;
    localparam int unsigned TMO   = 4;
`ifdef EXEC_SEQ_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic             imem_ack = 1'b0;
    logic             dmem_ack = 1'b0;
    logic             alu_out_b = 1'b0;
    instruction_set_t op = '0;
    encoding_type_t   en = '0;
    logic             imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we;
    logic             pc_load, pc_sel, busy, trap;
    logic [1:0]       wb_sel;
    logic [CNT_W-1:0] cycle_count, instret;

    execute_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .op(op), .en(en), .alu_out_b(alu_out_b),
        .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_load(pc_load), .pc_sel(pc_sel),
        .busy(busy), .trap(trap), .cycle_count(cycle_count), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             run, imem_ack, dmem_ack, out_b;
        instruction_set_t op;
        encoding_type_t   en;
        logic             imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we;
        logic             pc_load, pc_sel, busy, trap;
        logic [1:0]       wb_sel;
    } cyc_t;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_BR_TRUE, K_BR_FALSE, K_JUMP} kind_e;

    cyc_t            sched[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc_no = 0;
    longint unsigned exp_cyc = 0;
    longint unsigned exp_ret = 0;

    function automatic kind_e kind_of(op_idx_e idx);
        case (idx)
            OP_BEQ, OP_BLT, OP_BLTU:               return K_BR_TRUE;
            OP_BNE, OP_BGE, OP_BGEU:               return K_BR_FALSE;
            OP_JAL, OP_JALR:                       return K_JUMP;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:   return K_LOAD;
            OP_SB, OP_SH, OP_SW:                   return K_STORE;
            default:                               return K_ALU;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
        end
    endtask

    // Default cycle: every expected output low; inputs not meaningful in this cycle are noise.
    function automatic cyc_t blank(instruction_set_t o, encoding_type_t e);
        cyc_t c;
        c          = '0;
        c.op       = o;
        c.en       = e;
        c.run      = 1'($urandom);
        c.imem_ack = 1'($urandom);
        c.dmem_ack = 1'($urandom);
        c.out_b    = 1'($urandom);
        return c;
    endfunction

    function automatic encoding_type_t rand_enc();
        encoding_type_t e;
        e = '0;
        e[$urandom_range(0, ENC_W - 1)] = 1'b1;
        return e;
    endfunction

    task automatic push_idle(input bit r);
        cyc_t c;
        c     = blank('0, '0);
        c.run = r;
        sched.push_back(c);
    endtask

    task automatic push_trap(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c      = blank('0, '0);
            c.trap = 1'b1;
            sched.push_back(c);
        end
    endtask

    task automatic push_fetch(input instruction_set_t o, input encoding_type_t e, input int fwait);
        cyc_t c;
        for (int i = 0; i <= fwait; i++) begin
            c          = blank(o, e);
            c.imem_ack = (i == fwait);
            c.imem_req = 1'b1;
            c.ir_load  = (i == fwait);
            c.busy     = 1'b1;
            sched.push_back(c);
        end
    endtask

    // Full legal instruction: fetch, decode, exec, optional mem, writeback.
    task automatic push_instr(input op_idx_e idx, input int fwait, input int mwait,
                              input bit outb, input bit run_wb);
        instruction_set_t o;
        encoding_type_t   e;
        kind_e            k;
        cyc_t             c;
        o      = '0;
        o[idx] = 1'b1;
        e      = rand_enc();
        k      = kind_of(idx);
        push_fetch(o, e, fwait);
        c = blank(o, e); c.busy = 1'b1; sched.push_back(c);
        c = blank(o, e); c.busy = 1'b1; c.alu_en = 1'b1; c.out_b = outb; sched.push_back(c);
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i <= mwait; i++) begin
                c          = blank(o, e);
                c.busy     = 1'b1;
                c.dmem_req = 1'b1;
                c.dmem_we  = (k == K_STORE);
                c.dmem_ack = (i == mwait);
                sched.push_back(c);
            end
        end
        c         = blank(o, e);
        c.run     = run_wb;
        c.busy    = 1'b1;
        c.pc_load = 1'b1;
        c.pc_sel  = (k == K_JUMP) || (k == K_BR_TRUE && outb) || (k == K_BR_FALSE && !outb);
        c.rf_we   = !(k == K_BR_TRUE || k == K_BR_FALSE || k == K_STORE);
        c.wb_sel  = (k == K_LOAD) ? 2'd1 : (k == K_JUMP) ? 2'd2 : 2'd0;
        sched.push_back(c);
    endtask

    task automatic compare_rec(input cyc_t c);
        chk("imem_req", imem_req, c.imem_req);
        chk("ir_load", ir_load, c.ir_load);
        chk("alu_en", alu_en, c.alu_en);
        chk("dmem_req", dmem_req, c.dmem_req);
        chk("dmem_we", dmem_we, c.dmem_we);
        chk("rf_we", rf_we, c.rf_we);
        chk("wb_sel", wb_sel, c.wb_sel);
        chk("pc_load", pc_load, c.pc_load);
        chk("pc_sel", pc_sel, c.pc_sel);
        chk("busy", busy, c.busy);
        chk("trap", trap, c.trap);
        chk("cycle_count", cycle_count, exp_cyc);
        chk("instret", instret, exp_ret);
        if (PERF && c.busy)    exp_cyc++;
        if (PERF && c.pc_load) exp_ret++;
    endtask

    task automatic run_queue();
        cyc_t c;
        while (sched.size() > 0) begin
            c         = sched.pop_front();
            run       = c.run;
            imem_ack  = c.imem_ack;
            dmem_ack  = c.dmem_ack;
            alu_out_b = c.out_b;
            op        = c.op;
            en        = c.en;
            @(negedge clk);
            compare_rec(c);
            cyc_no++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_imem_req"}, imem_req, 0);
        chk({tag, "_ir_load"}, ir_load, 0);
        chk({tag, "_alu_en"}, alu_en, 0);
        chk({tag, "_dmem_req"}, dmem_req, 0);
        chk({tag, "_dmem_we"}, dmem_we, 0);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_wb_sel"}, wb_sel, 0);
        chk({tag, "_pc_load"}, pc_load, 0);
        chk({tag, "_pc_sel"}, pc_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_trap"}, trap, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
        chk({tag, "_instret"}, instret, 0);
    endtask

    task automatic do_reset();
        run       = 1'b0;
        imem_ack  = 1'b0;
        dmem_ack  = 1'b0;
        alu_out_b = 1'b0;
        op        = '0;
        en        = '0;
        reset     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset   = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        instruction_set_t o;
        op_idx_e          idx;
        bit               rw;

        // Directed: ADDI, taken BEQ, untaken BNE, LW with three wait cycles, then stop.
        do_reset();
        push_idle(1'b1);
        push_instr(OP_ADDI, 0, 0, 1'($urandom), 1'b1);
        push_instr(OP_BEQ, 0, 0, 1'b1, 1'b1);
        push_instr(OP_BNE, 0, 0, 1'b1, 1'b1);
        push_instr(OP_LW, 0, 3, 1'($urandom), 1'b0);
        push_idle(1'b0);
        run_queue();

        // Random instruction stream with random handshake waits and run gaps.
        push_idle(1'b1);
        for (int n = 0; n < 150; n++) begin
            idx = op_idx_e'($urandom_range(0, OP_COUNT - 1));
            rw  = (n != 149) && ($urandom_range(0, 4) != 0);
            push_instr(idx, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), rw);
            if (!rw) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) push_idle(1'b0);
                if (n != 149) push_idle(1'b1);
            end
        end
        run_queue();

        // Ten back-to-back ADDIs from reset: literal counter expectations.
        do_reset();
        push_idle(1'b1);
        for (int n = 0; n < 10; n++) push_instr(OP_ADDI, 0, 0, 1'($urandom), n != 9);
        push_idle(1'b0);
        run_queue();
        chk("lit_instret", instret, PERF ? 64'd10 : 64'd0);
        chk("lit_cycle_count", cycle_count, PERF ? 64'd40 : 64'd0);

        // Illegal op: trap reached in cycle 3 and held.
        do_reset();
        push_idle(1'b1);
        push_fetch('0, rand_enc(), 0);
        sched.push_back(blank('0, '0));
        sched[sched.size() - 1].busy = 1'b1;
        push_trap(6);
        run_queue();
        chk("lit_trap_sticky", trap, 1);
        chk("lit_trap_busy", busy, 0);

        // Zero encoding with a legal op also traps.
        do_reset();
        o = '0;
        o[OP_ADD] = 1'b1;
        push_idle(1'b1);
        push_fetch(o, '0, 2);
        sched.push_back(blank(o, '0));
        sched[sched.size() - 1].busy = 1'b1;
        push_trap(4);
        run_queue();

        // Fetch timeout: imem_req held four cycles without ack, then trap.
        do_reset();
        push_idle(1'b1);
        push_fetch(o, rand_enc(), 4);
        void'(sched.pop_back());
        push_trap(5);
        run_queue();

        // Data-memory timeout on a store.
        do_reset();
        push_idle(1'b1);
        push_instr(OP_SW, 1, 4, 1'b0, 1'b1);
        void'(sched.pop_back());
        void'(sched.pop_back());
        push_trap(4);
        run_queue();

        // Reset asserted mid-MEM drops the request within the same cycle.
        do_reset();
        push_idle(1'b1);
        push_instr(OP_LW, 0, 3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) void'(sched.pop_back());
        run_queue();
        dmem_ack = 1'b0;
        #2;
        chk("pre_reset_dmem_req", dmem_req, 1);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
